// File: rtl/latch_dump_serializer.sv
// Captures one pipeline latch snapshot word and streams it out LSB byte first over valid/ready.
// Optional LATCH_DUMP_HEADER_EN prefixes each frame with HEADER_BYTE.
module latch_dump_serializer #(
  parameter int         NB_DATA     = 75,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  localparam int        NB_BYTES    = (NB_DATA + 7) / 8,
  localparam int        NB_IDX      = $clog2(NB_BYTES + 1),
  localparam int        SHIFT_W     = NB_BYTES * 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_DATA-1:0] i_latch_data,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid,
  input  logic               i_byte_ready,
  output logic [NB_IDX-1:0]  o_byte_idx,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SEND, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q;
  logic [NB_IDX-1:0]    cnt_q;
  logic                 load;
  logic                 advance;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          load = 1'b1;
`ifdef LATCH_DUMP_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef LATCH_DUMP_HEADER_EN
      S_HEADER: begin
        if (i_byte_ready) state_d = S_SEND;
      end
`endif
      S_SEND: begin
        if (i_byte_ready) begin
          advance = 1'b1;
          if (cnt_q == NB_IDX'(NB_BYTES - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats both a same-cycle start and a same-cycle handshake.
    if (i_abort) begin
      state_d = S_IDLE;
      load    = 1'b0;
      advance = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= SHIFT_W'(i_latch_data);
      cnt_q   <= '0;
    end else if (advance) begin
      shift_q <= shift_q >> 8;
      cnt_q   <= cnt_q + NB_IDX'(1);
    end
  end

  // Outputs decode registered state only; ready/start never reach them combinationally.
  always_comb begin
    o_byte       = 8'h00;
    o_byte_valid = 1'b0;
    o_byte_idx   = '0;
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    case (state_q)
      S_HEADER: begin
        o_byte       = HEADER_BYTE;
        o_byte_valid = 1'b1;
      end
      S_SEND: begin
        o_byte       = shift_q[7:0];
        o_byte_valid = 1'b1;
        o_byte_idx   = cnt_q;
      end
      default: ;
    endcase
  end

endmodule
